// File: rtl/shift_arbiter.sv
// Two-requester arbiter that feeds one shared barrel shifter and registers its result.
// Define SHIFT_ARB_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.
module shift_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_shamt,
    input  logic        req0_shift,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_shamt,
    input  logic        req1_shift,
    output logic [31:0] bs_operand,
    output logic [4:0]  bs_shamt,
    output logic        bs_shift,
    input  logic [31:0] bs_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e state_q, state_d;
    logic   id_q;
    logic   grant_any;
    logic   grant_id;
    logic   accept;

`ifdef SHIFT_ARB_RR_EN
    logic ptr_q;

    // On contention the pointer names the favoured requester.
    always_comb begin
        grant_id = req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ptr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (accept) begin
            ptr_q <= ~grant_id;
        end
    end
`else
    always_comb begin
        grant_id = req1_valid && !req0_valid;
    end
`endif

    always_comb begin
        grant_any = req0_valid || req1_valid;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (grant_any) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic: readys only in IDLE and never while reset is high.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == StIdle && !reset) begin
            req0_ready = grant_any && !grant_id;
            req1_ready = grant_any && grant_id;
        end
        accept = req0_ready || req1_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bs_operand <= 32'h0;
            bs_shamt   <= 5'd0;
            bs_shift   <= 1'b0;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= 32'h0;
        end else begin
            if (accept) begin
                bs_operand <= grant_id ? req1_data  : req0_data;
                bs_shamt   <= grant_id ? req1_shamt : req0_shamt;
                bs_shift   <= grant_id ? req1_shift : req0_shift;
                id_q       <= grant_id;
            end
            if (state_q == StExec) begin
                rsp_data  <= bs_result;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end
            if (state_q == StResp && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_shift_arbiter;

`ifdef SHIFT_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_shift;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic        req1_valid, req1_ready, req1_shift;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic [31:0] bs_operand, bs_result, rsp_data;
    logic [4:0]  bs_shamt;
    logic        bs_shift, rsp_valid, rsp_ready, rsp_id;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    // Stand-in barrel shifter driven by the DUT's bs_* outputs.
    assign bs_result = bs_shift ? 32'($signed(bs_operand) >>> bs_shamt) : (bs_operand << bs_shamt);

    shift_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req0_shift (req0_shift),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .req1_shift (req1_shift),
        .bs_operand (bs_operand),
        .bs_shamt   (bs_shamt),
        .bs_shift   (bs_shift),
        .bs_result  (bs_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic t);
        if (!t) return d << s;
        if (d[31]) return ~((~d) >> s);
        return d >> s;
    endfunction

    task automatic test_reset();
        @(negedge clock);
        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = $urandom;
        req1_data  = $urandom;
        rsp_ready  = 1'b1;
        @(negedge clock);
        #1;
        vectors++;
        if ({req1_ready, req0_ready, rsp_valid, rsp_id, rsp_data, bs_operand, bs_shamt, bs_shift}
            !== 74'd0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b%b rv=%b id=%b rd=%h op=%h sh=%0d t=%b want all 0",
                     req1_ready, req0_ready, rsp_valid, rsp_id, rsp_data, bs_operand, bs_shamt,
                     bs_shift);
        end
        reset      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
    endtask

    task automatic test_single(input logic id, input logic [31:0] d, input logic [4:0] s,
                               input logic t, input logic [31:0] exp);
        @(negedge clock);
        rsp_ready  = 1'b0;
        req0_valid = !id;
        req1_valid = id;
        if (id) begin
            req1_data = d; req1_shamt = s; req1_shift = t;
        end else begin
            req0_data = d; req0_shamt = s; req0_shift = t;
        end
        #1;
        vectors++;
        if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL single_grant id=%0d: got ready=%b%b", id, req1_ready, req0_ready);
        end
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, bs_operand, bs_shamt, bs_shift, req1_ready, req0_ready}
            !== {1'b0, d, s, t, 2'b00}) begin
            miscompares++;
            $display("FAIL single_exec: got rv=%b op=%h sh=%0d t=%b rdy=%b%b want op=%h sh=%0d t=%b",
                     rsp_valid, bs_operand, bs_shamt, bs_shift, req1_ready, req0_ready, d, s, t);
        end
        @(negedge clock);
        #1;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, id, exp}) begin
            miscompares++;
            $display("FAIL single_rsp: got rv=%b id=%b data=%h want rv=1 id=%b data=%h",
                     rsp_valid, rsp_id, rsp_data, id, exp);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_rsp_clear: got rv=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [4:0]  s;
        logic        t;
        logic [31:0] exp;
        d = $urandom; s = 5'($urandom_range(0, 31)); t = 1'($urandom_range(0, 1));
        exp = ref_shift(d, s, t);
        @(negedge clock);
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_data = d; req0_shamt = s; req0_shift = t;
        @(negedge clock);
        req0_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            req1_valid = 1'b1;
            req1_data  = $urandom;
            rsp_ready  = (k == 3);
            #1;
            vectors++;
            if ({rsp_valid, rsp_id, rsp_data, req1_ready, req0_ready} !== {1'b1, 1'b0, exp, 2'b00})
            begin
                miscompares++;
                $display("FAIL hold_rsp cycle %0d: got rv=%b id=%b data=%h rdy=%b%b want data=%h",
                         k, rsp_valid, rsp_id, rsp_data, req1_ready, req0_ready, exp);
            end
        end
        @(negedge clock);
        rsp_ready = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, req1_ready, req0_ready} !== 3'b010) begin
            miscompares++;
            $display("FAIL hold_release: got rv=%b rdy=%b%b want rv=0 rdy=10",
                     rsp_valid, req1_ready, req0_ready);
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_exec();
        @(negedge clock);
        req0_valid = 1'b1; req0_data = 32'hDEADBEEF; req0_shamt = 5'd7; req0_shift = 1'b1;
        @(negedge clock);
        reset      = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        @(negedge clock);
        #1;
        vectors++;
        if ({req1_ready, req0_ready, rsp_valid, rsp_id, rsp_data, bs_operand, bs_shamt, bs_shift}
            !== 74'd0) begin
            miscompares++;
            $display("FAIL reset_exec: got rdy=%b%b rv=%b id=%b rd=%h op=%h sh=%0d t=%b want all 0",
                     req1_ready, req0_ready, rsp_valid, rsp_id, rsp_data, bs_operand, bs_shamt,
                     bs_shift);
        end
        reset      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            #1;
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stale_rsp cycle %0d: got rv=%b want 0", k, rsp_valid);
            end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_contention();
        logic exp_ptr;
        logic exp_gid;
        int   grants;
        exp_ptr = 1'b0;
        grants  = 0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clock);
            req0_valid = 1'b1; req0_data = $urandom; req0_shamt = 5'($urandom_range(0, 31));
            req1_valid = 1'b1; req1_data = $urandom; req1_shamt = 5'($urandom_range(0, 31));
            #1;
            if (req0_ready || req1_ready) begin
                exp_gid = RrEn ? exp_ptr : 1'b0;
                vectors++;
                if ({req1_ready, req0_ready} !== (exp_gid ? 2'b10 : 2'b01)) begin
                    miscompares++;
                    $display("FAIL contention grant %0d: got ready=%b%b want grant %0d",
                             grants, req1_ready, req0_ready, exp_gid);
                end
                exp_ptr = ~exp_gid;
                grants++;
            end
        end
        vectors++;
        if (grants != 6) begin
            miscompares++;
            $display("FAIL contention_count: got %0d grants want 6", grants);
        end
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
    endtask

    task automatic test_random();
        bit          busy;
        int          age;
        logic        m_ptr, m_id, m_shift;
        logic [31:0] m_data;
        logic [4:0]  m_shamt;
        logic        g_any, g_id;
        busy = 0; age = 0; m_ptr = 0; m_id = 0; m_shift = 0; m_data = 0; m_shamt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            reset      = (i == 0) || ($urandom_range(0, 49) == 0);
            req0_valid = 1'($urandom_range(0, 1));
            req0_data  = $urandom;
            req0_shamt = 5'($urandom_range(0, 31));
            req0_shift = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req1_data  = $urandom;
            req1_shamt = 5'($urandom_range(0, 31));
            req1_shift = 1'($urandom_range(0, 1));
            rsp_ready  = ($urandom_range(0, 2) != 0);
            #1;
            if (i > 0) begin
                g_any = !reset && !busy && (req0_valid || req1_valid);
                g_id  = (req0_valid && req1_valid) ? (RrEn ? m_ptr : 1'b0) : req1_valid;
                vectors++;
                if ({req1_ready, req0_ready} !== (g_any ? (g_id ? 2'b10 : 2'b01) : 2'b00)) begin
                    miscompares++;
                    $display("FAIL rand_ready @%0d: got %b%b want any=%b id=%b",
                             i, req1_ready, req0_ready, g_any, g_id);
                end
                vectors++;
                if (rsp_valid !== (busy && age >= 1)) begin
                    miscompares++;
                    $display("FAIL rand_rsp_valid @%0d: got %b want %b", i, rsp_valid,
                             busy && age >= 1);
                end
                vectors++;
                if ({bs_operand, bs_shamt, bs_shift} !== {m_data, m_shamt, m_shift}) begin
                    miscompares++;
                    $display("FAIL rand_bs @%0d: got op=%h sh=%0d t=%b want op=%h sh=%0d t=%b",
                             i, bs_operand, bs_shamt, bs_shift, m_data, m_shamt, m_shift);
                end
                if (busy && age >= 1) begin
                    vectors++;
                    if ({rsp_id, rsp_data} !== {m_id, ref_shift(m_data, m_shamt, m_shift)}) begin
                        miscompares++;
                        $display("FAIL rand_rsp @%0d: got id=%b data=%h want id=%b data=%h",
                                 i, rsp_id, rsp_data, m_id, ref_shift(m_data, m_shamt, m_shift));
                    end
                end
            end else begin
                g_any = 1'b0;
                g_id  = 1'b0;
            end
            // Advance the model across the coming edge.
            if (reset) begin
                busy = 0; age = 0; m_ptr = 0; m_id = 0;
                m_data = 0; m_shamt = 0; m_shift = 0;
            end else if (g_any) begin
                busy = 1; age = 0; m_id = g_id;
                m_data  = g_id ? req1_data  : req0_data;
                m_shamt = g_id ? req1_shamt : req0_shamt;
                m_shift = g_id ? req1_shift : req0_shift;
                if (RrEn) m_ptr = ~g_id;
            end else if (busy && age == 0) begin
                age = 1;
            end else if (busy && rsp_ready) begin
                busy = 0;
            end
        end
        @(negedge clock);
        reset      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0; req0_data = 32'h0; req0_shamt = 5'd0; req0_shift = 1'b0;
        req1_valid = 1'b0; req1_data = 32'h0; req1_shamt = 5'd0; req1_shift = 1'b0;
        rsp_ready  = 1'b0;
        test_reset();
        test_single(1'b0, 32'h00000001, 5'd4,  1'b0, 32'h00000010);
        test_single(1'b1, 32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF);
        test_single(1'b0, 32'h12345678, 5'd0,  1'b1, 32'h12345678);
        test_backpressure();
        test_reset_exec();
        test_contention();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
